// File: rtl/escalonador_rr_pkg.sv
// Shared constants for the round-robin process scheduler: sizing, FSM state
// encoding and the SO pid.
package escalonador_rr_pkg;

  localparam int NPROC   = 4;
  localparam int PID_W   = $clog2(NPROC);
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_SO   = 3'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 3'd1;
  localparam logic [STATE_W-1:0] S_SAVE = 3'd2;
  localparam logic [STATE_W-1:0] S_PICK = 3'd3;
  localparam logic [STATE_W-1:0] S_LOAD = 3'd4;

  localparam logic [PID_W-1:0] PID_SO = '0;

  // Settled states are the only ones where the CPU owner is stable.
  function automatic logic is_settled(input logic [STATE_W-1:0] s);
    return (s == S_SO) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/escalonador_rr_prox_pronto.sv
// Combinational round-robin search: first ready user pid after cur_pid,
// wrapping, with cur_pid itself checked last so a lone process is re-selected.
module escalonador_rr_prox_pronto
  import escalonador_rr_pkg::*;
(
  input  logic [NPROC-1:0] ready_mask,
  input  logic [PID_W-1:0] cur_pid,
  output logic             found,
  output logic [PID_W-1:0] next_pid
);

  logic [PID_W-1:0] cand;

  always_comb begin
    found    = 1'b0;
    next_pid = PID_SO;
    cand     = cur_pid;
    // Offsets 1..NPROC wrap on PID_W bits; offset NPROC lands back on cur_pid.
    for (int i = 1; i <= NPROC; i++) begin
      cand = cur_pid + PID_W'(i);
      if (!found && (cand != PID_SO) && ready_mask[cand]) begin
        found    = 1'b1;
        next_pid = cand;
      end
    end
  end

endmodule

// File: rtl/escalonador_rr.sv
// Round-robin scheduler: picks the next pid and sequences the context
// save/load handshake around every process switch.
//
// Handshake: Set_ctx (save of id_proc) and load_ctx (load of id_next) are
// levels held for as long as the FSM sits in S_SAVE / S_LOAD; a single-cycle
// ctx_ack sampled high in that state completes the transfer. ctx_ack seen in
// any other state has no effect.
module escalonador_rr
  import escalonador_rr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               quantum_over,
  input  logic               preemp_mode,
  input  logic               halt_proc,
  input  logic               so_dispatch,
  input  logic               proc_create,
  input  logic [PID_W-1:0]   create_pid,
  input  logic               ctx_ack,
  output logic [PID_W-1:0]   id_proc,
  output logic               Set_ctx,
  output logic               load_ctx,
  output logic [PID_W-1:0]   id_next,
  output logic               Set_pid_0,
  output logic               quantum_rst,
  output logic               busy,
  output logic [NPROC-1:0]   ready_mask,
  output logic [STATE_W-1:0] fsm_state
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [NPROC-1:0]   mask_d;
  logic               found;
  logic [PID_W-1:0]   pick_pid;
  logic               halt_take;
  logic               preempt_take;
  logic               load_done;

  escalonador_rr_prox_pronto u_prox_pronto (
    .ready_mask (ready_mask),
    .cur_pid    (id_proc),
    .found      (found),
    .next_pid   (pick_pid)
  );

  // halt_proc beats quantum_over; both are dead outside S_RUN.
  assign halt_take    = (state_q == S_RUN) && halt_proc;
  assign preempt_take = (state_q == S_RUN) && !halt_proc && quantum_over && preemp_mode;
  assign load_done    = (state_q == S_LOAD) && ctx_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SO: begin
        if (so_dispatch && (|ready_mask)) state_d = S_PICK;
      end
      S_RUN: begin
        if (halt_take)         state_d = S_PICK;
        else if (preempt_take) state_d = S_SAVE;
      end
      S_SAVE: begin
        if (ctx_ack) state_d = S_PICK;
      end
      S_PICK: begin
        state_d = found ? S_LOAD : S_SO;
      end
      S_LOAD: begin
        if (ctx_ack) state_d = S_RUN;
      end
      default: state_d = S_SO;
    endcase
  end

  // Create is applied after the halt clear so it wins on the same bit.
  always_comb begin
    mask_d = ready_mask;
    if (halt_take) mask_d[id_proc] = 1'b0;
    if (proc_create && (create_pid != PID_SO)) mask_d[create_pid] = 1'b1;
    mask_d[PID_SO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_SO;
      id_proc     <= PID_SO;
      id_next     <= PID_SO;
      ready_mask  <= '0;
      Set_pid_0   <= 1'b0;
      quantum_rst <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_mask  <= mask_d;
      Set_pid_0   <= (state_q == S_PICK) && !found;
      quantum_rst <= load_done;
      if (state_q == S_PICK) begin
        if (found) id_next <= pick_pid;
        else       id_proc <= PID_SO;
      end
      if (load_done) id_proc <= id_next;
    end
  end

  assign Set_ctx   = (state_q == S_SAVE);
  assign load_ctx  = (state_q == S_LOAD);
  assign busy      = !is_settled(state_q);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_escalonador_rr.sv
// Bench for escalonador_rr: directed scenarios plus random operations,
// scored against a set-based round-robin reference model.
module tb_escalonador_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       quantum_over = 1'b0;
  logic       preemp_mode = 1'b1;
  logic       halt_proc = 1'b0;
  logic       so_dispatch = 1'b0;
  logic       proc_create = 1'b0;
  logic [1:0] create_pid = 2'd0;
  logic       ctx_ack;
  logic [1:0] id_proc;
  logic       Set_ctx;
  logic       load_ctx;
  logic [1:0] id_next;
  logic       Set_pid_0;
  logic       quantum_rst;
  logic       busy;
  logic [3:0] ready_mask;
  logic [2:0] fsm_state;

  escalonador_rr dut (
    .clk          (clk),
    .reset        (reset),
    .quantum_over (quantum_over),
    .preemp_mode  (preemp_mode),
    .halt_proc    (halt_proc),
    .so_dispatch  (so_dispatch),
    .proc_create  (proc_create),
    .create_pid   (create_pid),
    .ctx_ack      (ctx_ack),
    .id_proc      (id_proc),
    .Set_ctx      (Set_ctx),
    .load_ctx     (load_ctx),
    .id_next      (id_next),
    .Set_pid_0    (Set_pid_0),
    .quantum_rst  (quantum_rst),
    .busy         (busy),
    .ready_mask   (ready_mask),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: {expected owner pid, expected ready mask}.
  logic [5:0] exp_q[$];

  // Reference model: set of ready user pids and the pid owning the CPU (0 = SO).
  logic [3:0] model_ready = 4'b0;
  int         model_cur   = 0;

  // Ack responder controls.
  int   ack_delay   = 0;
  bit   ack_rand    = 1'b0;
  bit   ack_load_en = 1'b1;
  int   ack_wait    = 0;
  bit   in_req      = 1'b0;

  // Observers.
  bit         saw_save    = 1'b0;
  int         save_cycles = 0;
  logic [1:0] last_load_id = 2'd0;

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, required);
    end
  endtask

  function automatic int rr_next(input int from);
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (from + k) % 4;
      if (p != 0 && model_ready[p]) return p;
    end
    return 0;
  endfunction

  // ---------------- ack responder ----------------
  initial begin
    ctx_ack = 1'b0;
    forever begin
      @(negedge clk);
      ctx_ack = 1'b0;
      if (reset && (Set_ctx || (load_ctx && ack_load_en))) begin
        if (!in_req) begin
          in_req   = 1'b1;
          ack_wait = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (ack_wait == 0) begin
          ctx_ack = 1'b1;
          in_req  = 1'b0;
        end else begin
          ack_wait--;
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // ---------------- observers ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (Set_ctx === 1'b1) begin
        saw_save = 1'b1;
        save_cycles++;
      end
      if (load_ctx === 1'b1) last_load_id = id_next;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("handshake_exclusive", int'(Set_ctx && load_ctx), 0);
        if (quantum_rst || Set_pid_0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got pid=%0d mask=%b set_pid_0=%0d, expected no event",
                     id_proc, ready_mask, Set_pid_0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_set_pid_0", int'(Set_pid_0), int'(e[5:4] == 2'd0));
            check("event_quantum_rst", int'(quantum_rst), int'(e[5:4] != 2'd0));
            check("event_id_proc", int'(id_proc), int'(e[5:4]));
            check("event_ready_mask", int'(ready_mask), int'(e[3:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int cnt = 0;
    repeat (3) @(negedge clk);
    while ((busy || exp_q.size() != 0) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("settle_timeout", int'(cnt >= 300), 0);
    @(negedge clk);
  endtask

  task automatic op_create(input int pid);
    @(negedge clk);
    proc_create = 1'b1;
    create_pid  = 2'(pid);
    @(negedge clk);
    proc_create = 1'b0;
    if (pid != 0) model_ready[pid] = 1'b1;
  endtask

  task automatic op_dispatch();
    @(negedge clk);
    so_dispatch = 1'b1;
    @(negedge clk);
    so_dispatch = 1'b0;
    if (model_cur == 0 && model_ready != 4'b0) begin
      model_cur = rr_next(0);
      exp_q.push_back({2'(model_cur), model_ready});
    end
    wait_idle();
  endtask

  task automatic op_quantum(input bit mode);
    @(negedge clk);
    quantum_over = 1'b1;
    preemp_mode  = mode;
    @(negedge clk);
    quantum_over = 1'b0;
    preemp_mode  = 1'b1;
    if (mode && model_cur != 0) begin
      model_cur = rr_next(model_cur);
      exp_q.push_back({2'(model_cur), model_ready});
    end
    wait_idle();
  endtask

  task automatic op_halt(input bit with_q);
    @(negedge clk);
    halt_proc    = 1'b1;
    quantum_over = with_q;
    @(negedge clk);
    halt_proc    = 1'b0;
    quantum_over = 1'b0;
    if (model_cur != 0) begin
      model_ready[model_cur] = 1'b0;
      model_cur = rr_next(model_cur);
      exp_q.push_back({2'(model_cur), model_ready});
    end
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] held_id;
    int         cnt;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_id_proc", int'(id_proc), 0);
    check("reset_id_next", int'(id_next), 0);
    check("reset_ready_mask", int'(ready_mask), 0);
    check("reset_set_ctx", int'(Set_ctx), 0);
    check("reset_load_ctx", int'(load_ctx), 0);
    check("reset_set_pid_0", int'(Set_pid_0), 0);
    check("reset_quantum_rst", int'(quantum_rst), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b1;

    // First dispatch with immediate acks: pid 1, no save.
    op_create(1);
    op_create(2);
    check("mask_after_create", int'(ready_mask), 4'b0110);
    saw_save = 1'b0;
    op_dispatch();
    check("first_dispatch_no_save", int'(saw_save), 0);
    check("first_dispatch_id", int'(id_proc), 1);

    // Preemption with a 3-cycle save ack.
    ack_delay   = 2;
    save_cycles = 0;
    op_quantum(1'b1);
    check("save_held_cycles", save_cycles, 3);
    check("load_id_next", int'(last_load_id), 2);
    check("preempt_id", int'(id_proc), 2);
    ack_delay = 0;

    // Halt and quantum together: halt wins, no save.
    saw_save = 1'b0;
    op_halt(1'b1);
    check("halt_priority_no_save", int'(saw_save), 0);
    check("halt_next_id", int'(id_proc), 1);

    // Drain to SO, then run lone pid 3 and halt it.
    op_halt(1'b0);
    op_create(3);
    op_dispatch();
    check("lone_pid3_running", int'(id_proc), 3);
    op_halt(1'b0);
    check("so_id_proc", int'(id_proc), 0);
    check("so_mask_empty", int'(ready_mask), 0);
    check("so_state", int'(fsm_state), int'(escalonador_rr_pkg::S_SO));
    op_dispatch();
    check("empty_dispatch_ignored_busy", int'(busy), 0);
    check("empty_dispatch_ignored_id", int'(id_proc), 0);

    // Preemption disabled: quantum_over held for 10 cycles.
    op_create(1);
    op_dispatch();
    held_id = id_proc;
    check("nopreempt_start_id", int'(held_id), 1);
    @(negedge clk);
    preemp_mode  = 1'b0;
    quantum_over = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nopreempt_busy", int'(busy), 0);
      check("nopreempt_id", int'(id_proc), 1);
    end
    quantum_over = 1'b0;
    preemp_mode  = 1'b1;
    wait_idle();

    // Random operations with random ack delays.
    ack_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (model_cur == 0) begin
        case ($urandom_range(0, 3))
          0, 1: op_create(int'($urandom_range(0, 3)));
          2:    op_dispatch();
          default: op_halt(1'($urandom_range(0, 1)));
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0: op_create(int'($urandom_range(0, 3)));
          1: op_quantum(1'b1);
          2: op_quantum(1'b0);
          3: op_halt(1'($urandom_range(0, 1)));
          default: op_halt(1'b0);
        endcase
      end
    end
    wait_idle();
    check("random_final_id", int'(id_proc), model_cur);
    check("random_final_mask", int'(ready_mask), int'(model_ready));

    // Reset while load_ctx is pending.
    ack_rand = 1'b0;
    ack_delay = 0;
    if (model_cur == 0) begin
      op_create(2);
      op_dispatch();
    end
    ack_load_en = 1'b0;
    @(negedge clk);
    quantum_over = 1'b1;
    preemp_mode  = 1'b1;
    @(negedge clk);
    quantum_over = 1'b0;
    cnt = 0;
    while (!load_ctx && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("load_ctx_reached", int'(load_ctx), 1);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    model_ready = 4'b0;
    model_cur   = 0;
    check("midload_reset_id_proc", int'(id_proc), 0);
    check("midload_reset_load_ctx", int'(load_ctx), 0);
    check("midload_reset_mask", int'(ready_mask), 0);
    check("midload_reset_busy", int'(busy), 0);
    reset = 1'b1;
    ack_load_en = 1'b1;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected completion");
    $fatal(1, "timeout");
  end

endmodule
